stream_word_unpacker: RTL and testbench

Parametrised stream unpacker placed between the DE1-SoC 32-bit word stream and the image preprocessing pipeline. Buffers incoming bus words in a small FIFO and emits them one element per cycle, ELEM_W bits at a time. Tracks frame boundaries: it marks the last element of each FRAME_LEN-element frame and counts completed frames. Uses the same valid/stall handshake as the top-level adapter on both sides.

---
 rtl/stream_word_unpacker.sv | 147 ++++++++++++++
 tb/tb_stream_word_unpacker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_word_unpacker.sv
// Stream word unpacker: buffers IN_W-bit words in a small FIFO and presents
// them one ELEM_W-bit element per cycle. It also flags the last element of
// each FRAME_LEN-element frame and counts completed frames.
module stream_word_unpacker #(
  parameter int IN_W       = 32,
  parameter int ELEM_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LSB_FIRST  = 1,
  parameter int FRAME_LEN  = 784
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              upstream_stall,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              downstream_stall,
  output logic [15:0]       frame_count
);

  localparam int ELEMS  = IN_W / ELEM_W;
  localparam int LANE_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(ELEMS - 1);
  localparam logic [FCNT_W-1:0] LAST_ELEM = FCNT_W'((FRAME_LEN > 0) ? FRAME_LEN - 1 : 0);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  logic [IN_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [IN_W-1:0]   r_word;
  logic [LANE_W-1:0] r_lane;
  logic              r_out_valid;
  logic [ELEM_W-1:0] r_out_data;
  logic              r_out_last;
  logic [FCNT_W-1:0] r_elem_cnt;
  logic [15:0]       r_frame_count;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_xfer;
  logic              w_last_lane_xfer;
  logic              w_valid_next;
  logic [FCNT_W-1:0] w_cnt_next;
  logic [IN_W-1:0]   w_head;

  // Lane k of a word, in either lane order.
  function automatic logic [ELEM_W-1:0] f_lane(input logic [IN_W-1:0] word,
                                               input logic [LANE_W-1:0] lane);
    int idx;
    idx = int'(lane);
    if (LSB_FIRST != 0) return word[idx*ELEM_W +: ELEM_W];
    else                return word[IN_W-1-idx*ELEM_W -: ELEM_W];
  endfunction

  assign w_full           = (r_count == FULL_CNT);
  assign w_empty          = (r_count == '0);
  assign w_push           = in_valid && !w_full;
  assign w_xfer           = r_out_valid && !downstream_stall;
  assign w_last_lane_xfer = w_xfer && (r_lane == LAST_LANE);
  // Refill the unpack register on the same edge its last lane leaves, so
  // consecutive words stream without a bubble.
  assign w_pop            = (!r_out_valid || w_last_lane_xfer) && !w_empty;
  assign w_head           = r_mem[r_rd_ptr];

  // Next-cycle view of the presented element, used to register out_last.
  always_comb begin
    w_valid_next = r_out_valid;
    if (w_pop)                 w_valid_next = 1'b1;
    else if (w_last_lane_xfer) w_valid_next = 1'b0;
    w_cnt_next = r_elem_cnt;
    if (w_xfer) w_cnt_next = (r_elem_cnt == LAST_ELEM) ? '0 : r_elem_cnt + 1'b1;
  end

  // FIFO storage; contents are don't-care while the occupancy count is zero.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Unpack register: load a fresh word at lane 0 or step to the next lane.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word      <= '0;
      r_lane      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_pop) begin
      r_word      <= w_head;
      r_lane      <= '0;
      r_out_valid <= 1'b1;
      r_out_data  <= f_lane(w_head, '0);
    end else if (w_xfer) begin
      if (r_lane == LAST_LANE) begin
        r_out_valid <= 1'b0;
      end else begin
        r_lane     <= r_lane + 1'b1;
        r_out_data <= f_lane(r_word, r_lane + 1'b1);
      end
    end
  end

  // Frame position, last-element flag and completed-frame counter.
  always_ff @(posedge clock) begin
    if (reset || FRAME_LEN == 0) begin
      r_elem_cnt    <= '0;
      r_out_last    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_elem_cnt <= w_cnt_next;
      r_out_last <= w_valid_next && (w_cnt_next == LAST_ELEM);
      if (w_xfer && r_elem_cnt == LAST_ELEM) r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign upstream_stall = w_full;
  assign out_data       = r_out_data;
  assign out_valid      = r_out_valid;
  assign out_last       = r_out_last;
  assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_stream_word_unpacker.sv
// Bench for stream_word_unpacker: three instances share one stimulus stream
// (defaults; FRAME_LEN=6; LSB_FIRST=0 with FRAME_LEN=0). A driver pushes the
// expected elements into per-instance queues on every accepted word and a
// monitor pops and compares them on every output transfer.
module tb_stream_word_unpacker;

  logic        clock;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        downstream_stall;

  logic        stall_a, valid_a, last_a;
  logic [7:0]  data_a;
  logic [15:0] fc_a;
  logic        stall_b, valid_b, last_b;
  logic [7:0]  data_b;
  logic [15:0] fc_b;
  logic        stall_c, valid_c, last_c;
  logic [7:0]  data_c;
  logic [15:0] fc_c;

  stream_word_unpacker dut_a (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .upstream_stall(stall_a), .out_data(data_a), .out_valid(valid_a),
    .out_last(last_a), .downstream_stall(downstream_stall), .frame_count(fc_a));

  stream_word_unpacker #(.FRAME_LEN(6)) dut_b (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .upstream_stall(stall_b), .out_data(data_b), .out_valid(valid_b),
    .out_last(last_b), .downstream_stall(downstream_stall), .frame_count(fc_b));

  stream_word_unpacker #(.LSB_FIRST(0), .FRAME_LEN(0)) dut_c (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .upstream_stall(stall_c), .out_data(data_c), .out_valid(valid_c),
    .out_last(last_c), .downstream_stall(downstream_stall), .frame_count(fc_c));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_xfer_a = 0;
  int pos_b = 0;
  int exp_fc_b = 0;
  bit saw_stall = 0;
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  logic [8:0] q_c[$];
  int xfer_cycs[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_push(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      q_a.push_back({1'b0, w[8*k +: 8]});
      q_b.push_back({(pos_b == 5), w[8*k +: 8]});
      pos_b = (pos_b == 5) ? 0 : pos_b + 1;
      q_c.push_back({1'b0, w[31-8*k -: 8]});
    end
  endtask

  // Present a word until it is accepted; returns just after the accepting edge.
  task automatic send(input logic [31:0] w);
    bit acc;
    acc = 0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clock);
      if (!stall_a) begin
        model_push(w);
        acc = 1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word 0x%0h never accepted", w);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q_a.delete();
    q_b.delete();
    q_c.delete();
    pos_b = 0;
    exp_fc_b = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clock);
      #2;
      if (q_a.size() == 0 && q_b.size() == 0 && q_c.size() == 0 && !valid_a) done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d elements still expected", q_a.size());
    end
  endtask

  // Monitor: compare every transferred element against the scoreboard.
  initial forever begin
    logic [8:0] e;
    @(negedge clock);
    if (!reset) begin
      if (stall_a) saw_stall = 1;
      if (valid_a && !downstream_stall) begin
        if (q_a.size() == 0) check("a_spurious", {24'd0, data_a}, 32'hFFFF_FFFF);
        else begin
          e = q_a.pop_front();
          check("a_data", {24'd0, data_a}, {24'd0, e[7:0]});
          check("a_last", {31'd0, last_a}, {31'd0, e[8]});
          check("a_fcount", {16'd0, fc_a}, 32'd0);
        end
        n_xfer_a++;
        xfer_cycs.push_back(cyc);
      end
      if (valid_b && !downstream_stall) begin
        if (q_b.size() == 0) check("b_spurious", {24'd0, data_b}, 32'hFFFF_FFFF);
        else begin
          e = q_b.pop_front();
          check("b_data", {24'd0, data_b}, {24'd0, e[7:0]});
          check("b_last", {31'd0, last_b}, {31'd0, e[8]});
          check("b_fcount", {16'd0, fc_b}, exp_fc_b);
          if (e[8]) exp_fc_b++;
        end
      end
      if (valid_c && !downstream_stall) begin
        if (q_c.size() == 0) check("c_spurious", {24'd0, data_c}, 32'hFFFF_FFFF);
        else begin
          e = q_c.pop_front();
          check("c_data", {24'd0, data_c}, {24'd0, e[7:0]});
          check("c_last", {31'd0, last_c}, 32'd0);
          check("c_fcount", {16'd0, fc_c}, 32'd0);
        end
      end
    end
  end

  initial begin
    int base;
    bit found;
    reset = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    downstream_stall = 1'b0;
    #1;
    do_reset();

    // reset state
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    check("rst_data", {24'd0, data_a}, 32'd0);
    check("rst_last", {31'd0, last_a}, 32'd0);
    check("rst_stall", {31'd0, stall_a}, 32'd0);
    check("rst_fcount", {16'd0, fc_a}, 32'd0);

    // single word, latency and lane order
    send(32'h4433_2211);
    @(negedge clock);
    check("lat_t1_valid", {31'd0, valid_a}, 32'd0);
    @(negedge clock);
    check("lat_t2_valid", {31'd0, valid_a}, 32'd1);
    check("lat_t2_data", {24'd0, data_a}, 32'h11);
    check("msb_first_t2", {24'd0, data_c}, 32'h44);
    repeat (3) @(negedge clock);
    check("lat_t5_data", {24'd0, data_a}, 32'h44);
    @(negedge clock);
    check("lat_t6_valid", {31'd0, valid_a}, 32'd0);
    drain();

    // back-to-back burst with FIFO fill and producer stall
    do_reset();
    saw_stall = 0;
    xfer_cycs.delete();
    for (int w = 0; w < 8; w++)
      send({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    drain();
    check("burst_stall_seen", {31'd0, saw_stall}, 32'd1);
    check("burst_count", xfer_cycs.size(), 32'd32);
    if (xfer_cycs.size() == 32)
      check("burst_no_gaps", xfer_cycs[31] - xfer_cycs[0], 32'd31);

    // consumer stall holds the presented element
    send(32'h4433_2211);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clock);
      #1;
      if (valid_a && data_a == 8'h22) found = 1;
    end
    check("hold_found_22", {31'd0, found}, 32'd1);
    downstream_stall = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("hold_valid", {31'd0, valid_a}, 32'd1);
      check("hold_data", {24'd0, data_a}, 32'h22);
      @(posedge clock);
      #1;
    end
    downstream_stall = 1'b0;
    drain();

    // frame boundaries falling mid-word
    do_reset();
    send(32'h0403_0201);
    send(32'h0807_0605);
    send(32'h0C0B_0A09);
    drain();
    check("frame_count_b", {16'd0, fc_b}, 32'd2);
    check("frame_count_c", {16'd0, fc_c}, 32'd0);

    // reset in the middle of a word with the FIFO still holding words
    do_reset();
    base = n_xfer_a;
    send(32'h4433_2211);
    send(32'h5555_5555);
    send(32'h6666_6666);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clock);
      #1;
      if (n_xfer_a >= base + 2) found = 1;
    end
    check("mid_two_xfers", {31'd0, found}, 32'd1);
    do_reset();
    check("mid_rst_valid", {31'd0, valid_a}, 32'd0);
    check("mid_rst_stall", {31'd0, stall_a}, 32'd0);
    check("mid_rst_fcount", {16'd0, fc_b}, 32'd0);
    send(32'hDDCC_BBAA);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clock);
      #1;
      if (valid_a) found = 1;
    end
    check("post_rst_first", {24'd0, data_a}, 32'hAA);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
